// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
//   NOP_INSTR    : value returned on reset and on out-of-range reads (addi x0,x0,0)
//   imem_state_t : responder FSM states
//   WE_WRITE/READ: encodings of the we_re request bit
//   imem_req_t   : request fields captured when a transaction is accepted
package imem_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic        WE_WRITE  = 1'b1;
  localparam logic        WE_READ   = 1'b0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  mask;
    logic [31:0] data;
  } imem_req_t;
endpackage

// File: rtl/imem_array.sv
// DEPTH x 32-bit RAM built from four byte lanes.
//   clk     : clock
//   wr_en   : write strobe; lanes with be[i] set take wr_data byte i
//   be      : byte-lane enables
//   rd_en   : read strobe; rd_data is registered and holds between reads
//   addr    : word index shared by both ports
//   wr_data : write data
//   rd_data : synchronous read data
// Contents are never reset.
module imem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [3:0]           be,
  input  logic                 rd_en,
  input  logic [AW-1:0]        addr,
  input  logic [3:0][7:0]      wr_data,
  output logic [3:0][7:0]      rd_data
);
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en && be[l]) mem[addr] <= wr_data[l];
      if (rd_en)          rd_data[l] <= mem[addr];
    end
  end
endmodule

// File: rtl/instr_mem_responder.sv
// Responder for the core's instruction-memory port.
//   clk, rst    : clock, synchronous active-high reset
//   address_in  : byte address; bits [1:0] ignored
//   request     : transaction request, sampled only in IDLE
//   we_re       : 1 = write, 0 = read
//   mask        : write byte enables
//   data_in     : write data
//   instruction : last completed read (NOP after reset / out-of-range read)
//   valid       : one-cycle completion pulse
//   busy        : transaction in flight (WAIT or RESP)
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDRESS     = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDRESS-1:0]    address_in,
  input  logic                  request,
  input  logic                  we_re,
  input  logic [3:0]            mask,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  valid,
  output logic                  busy
);
  localparam int         IDX_W   = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  imem_state_t          state, state_d;
  logic [3:0]           cnt;
  logic [ADDRESS-3:0]   cap_addr;   // word address; byte offset dropped
  imem_req_t            cap_req;
  logic                 ram_sel;    // instruction comes from RAM (vs NOP)
  logic                 in_range;
  logic                 wr_en, rd_en;
  logic [31:0]          rd_data;

  // Any word-address bit above the index field marks the access out of range.
  assign in_range = (cap_addr >> IDX_W) == '0;

  // Gate with rst so an aborted RESP never lands a write.
  assign wr_en = !rst && state == RESP && cap_req.we == WE_WRITE && in_range;
  assign rd_en = !rst && state == RESP && cap_req.we == WE_READ  && in_range;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (request) state_d = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: if (cnt == '0) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      valid   <= 1'b0;
      ram_sel <= 1'b0;
    end else begin
      state <= state_d;
      valid <= (state == RESP);
      if (state == IDLE && request) begin
        cap_addr <= address_in[ADDRESS-1:2];
        cap_req  <= '{we: we_re, mask: mask, data: data_in};
        cnt      <= WS_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      // Only reads move the output; writes leave instruction untouched.
      if (state == RESP && cap_req.we == WE_READ) ram_sel <= in_range;
    end
  end

  imem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .be      (cap_req.mask),
    .rd_en   (rd_en),
    .addr    (cap_addr[IDX_W-1:0]),
    .wr_data (cap_req.data),
    .rd_data (rd_data)
  );

  assign instruction = ram_sel ? rd_data : NOP_INSTR;
  assign busy        = (state != IDLE);
endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instance a: WAIT_STATES=0, b: 3, c: 2
  logic        rst_a = 1, req_a = 0, we_a = 0;
  logic [31:0] addr_a = 0, din_a = 0;
  logic [3:0]  msk_a = 0;
  logic [31:0] ins_a;
  logic        vld_a, bsy_a;

  logic        rst_b = 1, req_b = 0, we_b = 0;
  logic [31:0] addr_b = 0, din_b = 0;
  logic [3:0]  msk_b = 0;
  logic [31:0] ins_b;
  logic        vld_b, bsy_b;

  logic        rst_c = 1, req_c = 0, we_c = 0;
  logic [31:0] addr_c = 0, din_c = 0;
  logic [3:0]  msk_c = 0;
  logic [31:0] ins_c;
  logic        vld_c, bsy_c;

  instr_mem_responder #(.WAIT_STATES(0)) dut_a (
    .clk(clk), .rst(rst_a), .address_in(addr_a), .request(req_a), .we_re(we_a),
    .mask(msk_a), .data_in(din_a), .instruction(ins_a), .valid(vld_a), .busy(bsy_a));
  instr_mem_responder #(.WAIT_STATES(3)) dut_b (
    .clk(clk), .rst(rst_b), .address_in(addr_b), .request(req_b), .we_re(we_b),
    .mask(msk_b), .data_in(din_b), .instruction(ins_b), .valid(vld_b), .busy(bsy_b));
  instr_mem_responder #(.WAIT_STATES(2)) dut_c (
    .clk(clk), .rst(rst_c), .address_in(addr_c), .request(req_c), .we_re(we_c),
    .mask(msk_c), .data_in(din_c), .instruction(ins_c), .valid(vld_c), .busy(bsy_c));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] exp_instr;
  } vec_t;

  // Full transaction on b, waiting a bounded time for valid.
  task automatic xact_b(input logic we, input logic [31:0] addr, input logic [3:0] m,
                        input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    req_b = 1; we_b = we; addr_b = addr; msk_b = m; din_b = d;
    @(negedge clk);
    req_b = 0;
    while (!vld_b && n < 20) begin @(negedge clk); n++; end
    chk("b_valid_timeout", {31'b0, n < 20}, 32'd1);
  endtask

  task automatic xact_c(input logic we, input logic [31:0] addr, input logic [3:0] m,
                        input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    req_c = 1; we_c = we; addr_c = addr; msk_c = m; din_c = d;
    @(negedge clk);
    req_c = 0;
    while (!vld_c && n < 20) begin @(negedge clk); n++; end
    chk("c_valid_timeout", {31'b0, n < 20}, 32'd1);
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1, 32'h0000_0000, 4'hF, 32'h0050_0093, NOP};
    vecs[1]  = '{1, 32'h0000_0004, 4'hF, 32'h0000_0113, NOP};
    vecs[2]  = '{1, 32'h0000_0008, 4'hF, 32'h1122_3344, NOP};
    vecs[3]  = '{0, 32'h0000_0000, 4'h0, 32'h0,         32'h0050_0093};
    vecs[4]  = '{0, 32'h0000_0004, 4'hF, 32'h0,         32'h0000_0113};
    vecs[5]  = '{1, 32'h0000_0008, 4'h5, 32'hDEAD_BEEF, 32'h0000_0113};
    vecs[6]  = '{0, 32'h0000_0008, 4'h0, 32'h0,         32'h11AD_33EF};
    vecs[7]  = '{0, 32'h0000_1000, 4'h0, 32'h0,         NOP};
    vecs[8]  = '{1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, NOP};
    vecs[9]  = '{0, 32'h0000_0000, 4'h0, 32'h0,         32'h0050_0093};
    vecs[10] = '{1, 32'h0000_0004, 4'h0, 32'h1234_5678, 32'h0050_0093};
    vecs[11] = '{0, 32'h0000_0004, 4'h0, 32'h0,         32'h0000_0113};
    vecs[12] = '{0, 32'h0000_0002, 4'h0, 32'h0,         32'h0050_0093};
    vecs[13] = '{0, 32'h8000_0008, 4'h0, 32'h0,         NOP};
    vecs[14] = '{0, 32'h0000_000A, 4'h0, 32'h0,         32'h11AD_33EF};

    // Reset state
    repeat (2) @(negedge clk);
    rst_a = 0; rst_b = 0; rst_c = 0;
    chk("a_rst_instr", ins_a, NOP);
    chk("a_rst_valid", {31'b0, vld_a}, 0);
    chk("a_rst_busy",  {31'b0, bsy_a}, 0);
    chk("b_rst_instr", ins_b, NOP);
    chk("c_rst_busy",  {31'b0, bsy_c}, 0);

    // Table-driven transactions on the zero-wait instance
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      req_a = 1; we_a = vecs[i].we; addr_a = vecs[i].addr;
      msk_a = vecs[i].mask; din_a = vecs[i].data;
      @(negedge clk);
      req_a = 0;
      chk($sformatf("v%0d_busy_n", i),  {31'b0, bsy_a}, 1);
      chk($sformatf("v%0d_valid_n", i), {31'b0, vld_a}, 0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'b0, vld_a}, 1);
      chk($sformatf("v%0d_busy", i),  {31'b0, bsy_a}, 0);
      chk($sformatf("v%0d_instr", i), ins_a, vecs[i].exp_instr);
      @(negedge clk);
      chk($sformatf("v%0d_valid_drop", i), {31'b0, vld_a}, 0);
    end

    // Back-to-back: request held with reads of 0x0
    @(negedge clk);
    req_a = 1; we_a = 0; addr_a = 32'h0;
    begin
      logic prev = 1'b0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (i == 10) req_a = 0;
        chk($sformatf("b2b_valid_%0d", i), {31'b0, vld_a}, {31'b0, (i % 2) == 0});
        chk($sformatf("b2b_consec_%0d", i), {31'b0, vld_a & prev}, 0);
        prev = vld_a;
      end
      chk("b2b_instr", ins_a, 32'h0050_0093);
    end

    // WAIT_STATES=3: busy for 4 cycles, valid after N+4, ignored requests
    xact_b(1, 32'h4, 4'hF, 32'h0000_0113);
    @(negedge clk);
    req_b = 1; we_b = 0; addr_b = 32'h4;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      req_b = (i == 2);   // stray request while busy
      chk($sformatf("ws3_busy_%0d", i),  {31'b0, bsy_b}, 1);
      chk($sformatf("ws3_valid_%0d", i), {31'b0, vld_b}, 0);
    end
    @(negedge clk);
    chk("ws3_valid", {31'b0, vld_b}, 1);
    chk("ws3_busy_done", {31'b0, bsy_b}, 0);
    chk("ws3_instr", ins_b, 32'h0000_0113);
    begin
      int extra = 0;
      for (int i = 0; i < 8; i++) begin @(negedge clk); extra += vld_b; end
      chk("ws3_extra_valid", extra, 0);
    end

    // WAIT_STATES=2: reset during WAIT aborts a write
    xact_c(1, 32'hC, 4'hF, 32'hA5A5_A5A5);
    xact_c(0, 32'hC, 4'h0, 32'h0);
    chk("c_pre_read", ins_c, 32'hA5A5_A5A5);
    @(negedge clk);
    req_c = 1; we_c = 1; addr_c = 32'hC; msk_c = 4'hF; din_c = 32'hFFFF_FFFF;
    @(negedge clk);
    req_c = 0;
    chk("c_wait_busy", {31'b0, bsy_c}, 1);
    rst_c = 1;
    @(negedge clk);
    rst_c = 0;
    chk("c_rst_instr", ins_c, NOP);
    chk("c_rst_valid", {31'b0, vld_c}, 0);
    chk("c_rst_busy2", {31'b0, bsy_c}, 0);
    begin
      int extra = 0;
      for (int i = 0; i < 5; i++) begin @(negedge clk); extra += vld_c; end
      chk("c_no_valid", extra, 0);
    end
    xact_c(0, 32'hC, 4'h0, 32'h0);
    chk("c_word3_kept", ins_c, 32'hA5A5_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Responder end of the core's instruction-memory port. It accepts `request`/`we_re`/`mask`/address beats from the fetch stage and serves word reads from an internal byte-lane RAM. It also performs masked writes, which are used for program loading. A programmable wait-state counter lets the bench model slow memory, and a `valid` pulse marks completion.

## Interface
- `DATA_WIDTH`, 32: word width; must be 32.
- `ADDRESS`, 32: address bus width.
- `DEPTH`, 1024: number of 32-bit words; must be a power of two.
- `WAIT_STATES`, 0: extra cycles inserted before the response (0..15).
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `address_in`  in  ADDRESS: byte address from the fetch stage.
- `request`  in  1: transaction request.
- `we_re`  in  1: 1 = write, 0 = read.
- `mask`  in  4: byte enables for writes; bit i maps to bits 8i+7:8i; ignored on reads.
- `data_in`  in  DATA_WIDTH: write data.
- `instruction`  out  DATA_WIDTH: read data returned to the core.
- `valid`  out  1: one-cycle completion pulse.
- `busy`  out  1: a transaction is in flight; new requests are ignored.

## Operation
- FSM states:
  - IDLE: if `request`, capture address, `we_re`, `mask`, `data_in`. Go to WAIT if `WAIT_STATES`>0, else RESP.
  - WAIT: count down from `WAIT_STATES`. At 0, go to RESP.
  - RESP: perform the access and pulse `valid`. Return to IDLE.
- Word index = `address_in[log2(DEPTH)+1:2]`. Bits [1:0] are ignored; there is no misalignment fault.
- Out-of-range address (any bit above the index field set):
  - read returns NOP 32'h0000_0013;
  - write is dropped;
  - `valid` still pulses.
- Read: `instruction` loads `mem[index]` in RESP and holds that value until the next completed read.
- Write: byte lanes with `mask` bit set are updated in RESP. `instruction` is unchanged. `mask`=0 is a legal no-op that still pulses `valid`.
- Requests are sampled only in IDLE. `request` in WAIT/RESP is ignored, not queued.
- Read-after-write to the same word returns the updated bytes.
- Memory contents are not reset; simulation preload is done via `$readmemh`.

## Timing
- Reset values: `instruction`=32'h0000_0013, `valid`=0, `busy`=0, state=IDLE, wait counter=0.
- Latency with `WAIT_STATES`=0: request sampled at edge N; `instruction` and `valid` visible after edge N+1. That is one transaction per 2 cycles.
- With `WAIT_STATES`=k: `valid` is visible after edge N+1+k.
- `busy` is high from the cycle after acceptance through the RESP cycle inclusive. It is low in IDLE.
- Back-to-back: a `request` held high is re-accepted in the IDLE cycle following RESP.
- `rst` mid-transaction:
  - aborts immediately; a pending write is not performed;
  - outputs return to reset values on the next edge;
  - memory contents are preserved.
- `valid` is never high for two consecutive cycles.

## Structure
- Shared package `imem_pkg`:
  - `NOP_INSTR` = 32'h0000_0013;
  - state enum `imem_state_t` {IDLE, WAIT, RESP};
  - `WE_WRITE`=1 / `WE_READ`=0 constants.
- Sub-module `imem_array`: `DEPTH`×32 RAM with 4 byte-lane write enables and a synchronous read port.
- The top holds the FSM, wait counter, capture registers, range check and output register.
- Core top instantiates this block on its `address_out`/`instruction_mem_*` pins.

## Test plan
- Preload word 0 = 32'h0050_0093, word 1 = 32'h0000_0113. With `WAIT_STATES`=0, read 0x0 then 0x4 -> `instruction` = 32'h0050_0093 then 32'h0000_0113, each one cycle after acceptance, each with a single `valid` pulse.
- Write 0x8 with data 32'hDEAD_BEEF and `mask`=4'b0101 over prior 32'h1122_3344, then read 0x8 -> 32'h11AD_33EF.
- `WAIT_STATES`=3: read 0x4 -> `busy` high 4 cycles; `valid` after edge N+4; `request` pulses during `busy` produce no extra `valid`.
- Read 0x0000_1000 with `DEPTH`=1024 -> `instruction` = 32'h0000_0013, `valid`=1. Write to that address leaves all words unchanged.
- `WAIT_STATES`=2: write 0xC, assert `rst` in the WAIT cycle -> no `valid`; word 3 keeps its old value; outputs return to NOP/0/0.
- `request` held high continuously with reads of 0x0 -> `valid` every other cycle and never in consecutive cycles.
